multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle MIPS control FSM; next generation of the single-cycle decoder. Sequences each instruction over
//  3-5 cycles, driving shared-ALU/unified-memory datapath muxes, with a memory-ready handshake, a bounded wait
//  timeout, illegal-opcode trap and a retired-instruction counter. Sits between the IR opcode field and datapath.
// PARAMETERS
//  CNT_W       16  width of instr_count; wraps modulo 2^CNT_W
//  WAIT_LIMIT  15  max cycles held in a memory state awaiting mem_ready; 0 = wait forever
// PORTS
//  clk          in   1  clock, all state changes on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  opcode       in   6  IR[31:26]; sampled only in DECODE
//  mem_ready    in   1  memory completes current access this cycle
//  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ZeroExt  out 1  datapath enables/selects
//  ALUSrcB      out  2  00 rt, 01 const 4, 10 imm, 11 imm<<2
//  ALUOp        out  3  000 add, 001 sub, 010 funct, 011 and, 100 or
//  RegDst       out  2  00 rt, 01 rd, 10 $31
//  MemToReg     out  2  00 ALUOut, 01 MDR, 10 PC
//  PCSource     out  2  00 ALU, 01 ALUOut, 10 jump target
//  branch_ne    out  1  PCWriteCond qualifies on !zero instead of zero
//  illegal_op   out  1  one-cycle pulse: undecodable opcode
//  mem_timeout  out  1  one-cycle pulse: WAIT_LIMIT exhausted
//  instr_count  out  CNT_W  retired instructions
//  state        out  4  current state (debug)
// BEHAVIOUR
//  - Outputs are Moore decodes of state (plus op_q in IMM_EXEC); unlisted outputs are 0 in every state.
//  - Reset (async, any time incl. mid-access): state=IDLE, op_q=0, wait_cnt=0, instr_count=0, pulses=0;
//    all outputs 0 immediately. IDLE -> FETCH on first clock after rst_n deasserts.
//  - FETCH(1): MemRead, ALUSrcB=01; IRWrite=PCWrite=mem_ready. Hold until mem_ready, then -> DECODE.
//  - DECODE(2): ALUSrcB=11 (branch target); op_q<=opcode. lw/sw(100011/101011)->MEM_ADDR; R(000000)->EXECUTE;
//    beq(000100)->BRANCH; addi/andi/ori(001000/001100/001101)->IMM_EXEC; jal(000011)->JAL; j(000010)->JUMP;
//    else -> FETCH, illegal_op=1 next cycle, instruction not counted.
//  - MEM_ADDR(3): ALUSrcA=1, ALUSrcB=10 -> MEM_READ (lw) / MEM_WRITE (sw).
//  - MEM_READ(4): MemRead, IorD; hold until mem_ready -> MEM_WB(5): MemToReg=01, RegWrite -> FETCH.
//  - MEM_WRITE(6): MemWrite, IorD; hold until mem_ready -> FETCH.
//  - EXECUTE(7): ALUSrcA=1, ALUOp=010 -> R_WB(8): RegDst=01, RegWrite -> FETCH.
//  - BRANCH(9): ALUSrcA=1, ALUOp=001, PCWriteCond, PCSource=01 -> FETCH.
//  - IMM_EXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp=000/011/100 for addi/andi/ori; ZeroExt=1 for andi/ori
//    -> IMM_WB(11): RegWrite -> FETCH.
//  - JAL(12): RegDst=10, MemToReg=10, RegWrite, PCWrite, PCSource=10 -> FETCH. JUMP(13): PCWrite, PCSource=10 -> FETCH.
//  - Codes 0,14,15 unreachable; if entered -> FETCH.
//  - wait_cnt: cleared on entry to FETCH/MEM_READ/MEM_WRITE, +1 each cycle held without mem_ready. When
//    WAIT_LIMIT!=0 and wait_cnt==WAIT_LIMIT-1 without mem_ready: -> FETCH, mem_timeout=1 next cycle, no writeback,
//    not counted (FETCH timeout re-fetches same PC since PCWrite never fired). mem_ready on limit cycle wins.
//  - instr_count +1 (wrapping) on every transition into FETCH from MEM_WB, MEM_WRITE(ready), R_WB, BRANCH,
//    IMM_WB, JAL, JUMP. Opcode changes outside DECODE have no effect.
// CONFIGURATION
//  - MCU_BNE_EN defined: bne(000101) decodes -> BRANCH with op_q tag; branch_ne=1 in BRANCH for bne, 0 for beq.
//  - Undefined: 000101 is illegal (illegal_op pulse); branch_ne tied 0.
// TESTING
//  - Reset mid MEM_READ (rst_n=0 for 1 cycle) -> outputs 0 same cycle, state=0, then FETCH, instr_count=0.
//  - lw, mem_ready=1 always -> states 1,2,3,4,5,1; RegWrite=1, MemToReg=01 in state 5; instr_count=1.
//  - sw, mem_ready low 3 cycles in MEM_WRITE (WAIT_LIMIT=15) -> MemWrite held 4 cycles, then FETCH, count +1.
//  - ori then andi then addi -> IMM_EXEC ALUOp=100/ZeroExt=1, 011/1, 000/0; count=3.
//  - opcode 6'b111111 -> DECODE->FETCH, illegal_op single pulse, count unchanged.
//  - WAIT_LIMIT=4, mem_ready=0 in FETCH -> 4 cycles in FETCH, mem_timeout pulse, PCWrite never 1;
//    bne with/without MCU_BNE_EN -> BRANCH branch_ne=1 / illegal_op pulse.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Opcode/handshake inputs and datapath control outputs of the multi-cycle MIPS control unit.
// master: the control unit itself; slave: the datapath / IR side.
interface multicycle_control_unit_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             PCWrite;
   logic             PCWriteCond;
   logic             IorD;
   logic             MemRead;
   logic             MemWrite;
   logic             IRWrite;
   logic             RegWrite;
   logic             ALUSrcA;
   logic             ZeroExt;
   logic [1:0]       ALUSrcB;
   logic [2:0]       ALUOp;
   logic [1:0]       RegDst;
   logic [1:0]       MemToReg;
   logic [1:0]       PCSource;
   logic             branch_ne;
   logic             illegal_op;
   logic             mem_timeout;
   logic [CNT_W-1:0] instr_count;
   logic [3:0]       state;

   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ZeroExt,
      output ALUSrcB, ALUOp, RegDst, MemToReg, PCSource, branch_ne,
      output illegal_op, mem_timeout, instr_count, state
   );

   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ZeroExt,
      input  ALUSrcB, ALUOp, RegDst, MemToReg, PCSource, branch_ne,
      input  illegal_op, mem_timeout, instr_count, state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with memory-ready wait timeout, illegal-opcode trap and retire counter.
// Define MCU_BNE_EN to decode bne (000101) as a branch; otherwise it traps as illegal.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | 0  after reset, one cycle
// FETCH     | 1  read instruction, PC+4 on mem_ready
// DECODE    | 2  latch opcode, precompute branch target
// MEM_ADDR  | 3  lw/sw effective address
// MEM_READ  | 4  lw data access
// MEM_WB    | 5  lw register writeback
// MEM_WRITE | 6  sw data access
// EXECUTE   | 7  R-type ALU operation
// R_WB      | 8  R-type writeback to rd
// BRANCH    | 9  beq/bne compare and conditional PC write
// IMM_EXEC  | 10 addi/andi/ori ALU operation
// IMM_WB    | 11 immediate writeback to rt
// JAL       | 12 link to $31 and jump
// JUMP      | 13 jump
module multicycle_control_unit #(
   parameter int CNT_W      = 16,
   parameter int WAIT_LIMIT = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   multicycle_control_unit_if.master bus
);
   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      EXECUTE   = 4'd7,
      R_WB      = 4'd8,
      BRANCH    = 4'd9,
      IMM_EXEC  = 4'd10,
      IMM_WB    = 4'd11,
      JAL       = 4'd12,
      JUMP      = 4'd13
   } state_e;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
`ifdef MCU_BNE_EN
   localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

   // Wait timer counts down from WAIT_LIMIT-1; terminal count with no mem_ready is the timeout.
   localparam int            TW       = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [TW-1:0] TMR_LOAD = (WAIT_LIMIT > 0) ? TW'(WAIT_LIMIT - 1) : '0;

   state_e           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ill_q, ill_d;
   logic             to_q, to_d;
   logic             hold_wait;
   logic             retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         tmr_q   <= '0;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      tmr_d     = tmr_q;
      cnt_d     = cnt_q;
      ill_d     = 1'b0;
      to_d      = 1'b0;
      hold_wait = 1'b0;
      retire    = 1'b0;
      case (state_q)
         IDLE:      state_d = FETCH;
         FETCH:     if (bus.mem_ready) state_d = DECODE; else hold_wait = 1'b1;
         DECODE: begin
            op_d = bus.opcode;
            case (bus.opcode)
               OP_LW, OP_SW:              state_d = MEM_ADDR;
               OP_R:                      state_d = EXECUTE;
               OP_BEQ:                    state_d = BRANCH;
`ifdef MCU_BNE_EN
               OP_BNE:                    state_d = BRANCH;
`endif
               OP_ADDI, OP_ANDI, OP_ORI:  state_d = IMM_EXEC;
               OP_JAL:                    state_d = JAL;
               OP_J:                      state_d = JUMP;
               default: begin
                  state_d = FETCH;
                  ill_d   = 1'b1;
               end
            endcase
         end
         MEM_ADDR:  state_d = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
         MEM_READ:  if (bus.mem_ready) state_d = MEM_WB; else hold_wait = 1'b1;
         MEM_WRITE: begin
            if (bus.mem_ready) begin
               state_d = FETCH;
               retire  = 1'b1;
            end else begin
               hold_wait = 1'b1;
            end
         end
         EXECUTE:   state_d = R_WB;
         IMM_EXEC:  state_d = IMM_WB;
         MEM_WB, R_WB, BRANCH, IMM_WB, JAL, JUMP: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         default:   state_d = FETCH;
      endcase

      if (hold_wait && (WAIT_LIMIT != 0)) begin
         if (tmr_q == '0) begin
            state_d = FETCH;
            to_d    = 1'b1;
         end else begin
            tmr_d = tmr_q - 1'b1;
         end
      end

      if (retire) cnt_d = cnt_q + 1'b1;

      // A timeout out of FETCH re-enters FETCH, so it must restart the timer too.
      if (((state_d == FETCH) || (state_d == MEM_READ) || (state_d == MEM_WRITE)) &&
          ((state_d != state_q) || to_d))
         tmr_d = TMR_LOAD;
   end

   always_comb begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ZeroExt     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.ALUOp       = 3'b000;
      bus.RegDst      = 2'b00;
      bus.MemToReg    = 2'b00;
      bus.PCSource    = 2'b00;
      bus.branch_ne   = 1'b0;
      case (state_q)
         FETCH: begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.IRWrite = bus.mem_ready;
            bus.PCWrite = bus.mem_ready;
         end
         DECODE:    bus.ALUSrcB = 2'b11;
         MEM_ADDR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
         end
         MEM_READ: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
         end
         MEM_WB: begin
            bus.MemToReg = 2'b01;
            bus.RegWrite = 1'b1;
         end
         MEM_WRITE: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
         end
         EXECUTE: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = 3'b010;
         end
         R_WB: begin
            bus.RegDst   = 2'b01;
            bus.RegWrite = 1'b1;
         end
         BRANCH: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUOp       = 3'b001;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = 2'b01;
`ifdef MCU_BNE_EN
            bus.branch_ne   = (op_q == OP_BNE);
`endif
         end
         IMM_EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            if (op_q == OP_ANDI) begin
               bus.ALUOp   = 3'b011;
               bus.ZeroExt = 1'b1;
            end else if (op_q == OP_ORI) begin
               bus.ALUOp   = 3'b100;
               bus.ZeroExt = 1'b1;
            end
         end
         IMM_WB:    bus.RegWrite = 1'b1;
         JAL: begin
            bus.RegDst   = 2'b10;
            bus.MemToReg = 2'b10;
            bus.RegWrite = 1'b1;
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b10;
         end
         JUMP: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b10;
         end
         default: ;
      endcase
   end

   assign bus.illegal_op  = ill_q;
   assign bus.mem_timeout = to_q;
   assign bus.instr_count = cnt_q;
   assign bus.state       = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected state/outputs queued when driven,
// popped and compared on the falling edge; a second instance with WAIT_LIMIT=4 covers the timeout.
module tb_multicycle_control_unit;
   localparam logic [3:0] IDL = 4'd0,  FET = 4'd1,  DEC = 4'd2,  MAD = 4'd3,  MRD = 4'd4;
   localparam logic [3:0] MWB = 4'd5,  MWR = 4'd6,  EXE = 4'd7,  RWB = 4'd8,  BRA = 4'd9;
   localparam logic [3:0] IEX = 4'd10, IWB = 4'd11, JLS = 4'd12, JMS = 4'd13;

   localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_JAL = 6'b000011, O_BEQ = 6'b000100;
   localparam logic [5:0] O_BNE = 6'b000101, O_ADDI = 6'b001000, O_ANDI = 6'b001100;
   localparam logic [5:0] O_ORI = 6'b001101, O_LW = 6'b100011, O_SW = 6'b101011, O_BAD = 6'b111111;

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] cnt;
      logic        ill;
      logic        to;
      logic [20:0] ctrl;
   } exp_t;

   logic clk;
   logic rst_n;
   logic rst_t_n;
   int   n_chk;
   int   n_err;
   exp_t sb[$];
   logic [5:0] cur_op;

   multicycle_control_unit_if #(.CNT_W(16)) u_if ();
   multicycle_control_unit_if #(.CNT_W(16)) t_if ();

   multicycle_control_unit #(.CNT_W(16), .WAIT_LIMIT(15)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   multicycle_control_unit #(.CNT_W(16), .WAIT_LIMIT(4)) u_dut_t (
      .clk   (clk),
      .rst_n (rst_t_n),
      .bus   (t_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [20:0] obs_ctrl;
   assign obs_ctrl = {u_if.PCWrite, u_if.PCWriteCond, u_if.IorD, u_if.MemRead, u_if.MemWrite,
                      u_if.IRWrite, u_if.RegWrite, u_if.ALUSrcA, u_if.ZeroExt, u_if.ALUSrcB,
                      u_if.ALUOp, u_if.RegDst, u_if.MemToReg, u_if.PCSource, u_if.branch_ne};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [20:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic rdy);
      logic pcw, pcwc, iord, mr, mw, irw, rw, asa, ze, bn;
      logic [1:0] asb, rd, m2r, pcs;
      logic [2:0] aop;
      {pcw, pcwc, iord, mr, mw, irw, rw, asa, ze, bn} = '0;
      {asb, rd, m2r, pcs} = '0;
      aop = 3'b000;
      case (st)
         FET: begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
         DEC: asb = 2'b11;
         MAD: begin asa = 1'b1; asb = 2'b10; end
         MRD: begin mr = 1'b1; iord = 1'b1; end
         MWB: begin m2r = 2'b01; rw = 1'b1; end
         MWR: begin mw = 1'b1; iord = 1'b1; end
         EXE: begin asa = 1'b1; aop = 3'b010; end
         RWB: begin rd = 2'b01; rw = 1'b1; end
         BRA: begin
            asa = 1'b1; aop = 3'b001; pcwc = 1'b1; pcs = 2'b01;
`ifdef MCU_BNE_EN
            bn = (op == O_BNE);
`endif
         end
         IEX: begin
            asa = 1'b1; asb = 2'b10;
            if (op == O_ANDI) begin aop = 3'b011; ze = 1'b1; end
            else if (op == O_ORI) begin aop = 3'b100; ze = 1'b1; end
         end
         IWB: rw = 1'b1;
         JLS: begin rd = 2'b10; m2r = 2'b10; rw = 1'b1; pcw = 1'b1; pcs = 2'b10; end
         JMS: begin pcw = 1'b1; pcs = 2'b10; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mr, mw, irw, rw, asa, ze, asb, aop, rd, m2r, pcs, bn};
   endfunction

   // Drive one cycle (opcode is random noise outside DECODE) and queue what that cycle must show.
   task automatic cyc(input logic [3:0] st, input logic rdy, input logic [5:0] op,
                      input int cnt, input logic ill, input logic to);
      exp_t e;
      u_if.mem_ready = rdy;
      u_if.opcode    = (st == DEC) ? op : 6'($urandom);
      if (st == DEC) cur_op = op;
      e.st   = st;
      e.cnt  = 16'(cnt);
      e.ill  = ill;
      e.to   = to;
      e.ctrl = exp_ctrl(st, cur_op, rdy);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("state",       32'(u_if.state),       32'(e.st));
         chk("instr_count", 32'(u_if.instr_count), 32'(e.cnt));
         chk("illegal_op",  32'(u_if.illegal_op),  32'(e.ill));
         chk("mem_timeout", 32'(u_if.mem_timeout), 32'(e.to));
         chk("ctrl",        32'(obs_ctrl),         32'(e.ctrl));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      logic nxt_ill;
      logic [5:0] imm_ops [3];
      imm_ops = '{O_ORI, O_ANDI, O_ADDI};
      n_chk = 0;
      n_err = 0;
      cur_op = '0;
      rst_n = 1'b0;
      rst_t_n = 1'b0;
      u_if.opcode = '0;
      u_if.mem_ready = 1'b1;
      t_if.opcode = O_LW;
      t_if.mem_ready = 1'b0;
      #3;
      chk("rst_state", 32'(u_if.state),       32'd0);
      chk("rst_ctrl",  32'(obs_ctrl),         32'd0);
      chk("rst_count", 32'(u_if.instr_count), 32'd0);
      chk("rst_pulse", 32'({u_if.illegal_op, u_if.mem_timeout}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(IDL, 1'b1, 6'd0, 0, 1'b0, 1'b0);

      // lw with memory always ready
      cyc(FET, 1'b1, 6'd0, 0, 1'b0, 1'b0);
      cyc(DEC, 1'b1, O_LW, 0, 1'b0, 1'b0);
      cyc(MAD, 1'b1, 6'd0, 0, 1'b0, 1'b0);
      cyc(MRD, 1'b1, 6'd0, 0, 1'b0, 1'b0);
      cyc(MWB, 1'b1, 6'd0, 0, 1'b0, 1'b0);

      // sw with three wait cycles
      cyc(FET, 1'b1, 6'd0, 1, 1'b0, 1'b0);
      cyc(DEC, 1'b1, O_SW, 1, 1'b0, 1'b0);
      cyc(MAD, 1'b1, 6'd0, 1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(MWR, 1'b0, 6'd0, 1, 1'b0, 1'b0);
      cyc(MWR, 1'b1, 6'd0, 1, 1'b0, 1'b0);

      c = 2;
      for (int i = 0; i < 3; i++) begin
         cyc(FET, 1'b1, 6'd0, c, 1'b0, 1'b0);
         cyc(DEC, 1'b1, imm_ops[i], c, 1'b0, 1'b0);
         cyc(IEX, 1'b1, 6'd0, c, 1'b0, 1'b0);
         cyc(IWB, 1'b1, 6'd0, c, 1'b0, 1'b0);
         c++;
      end

      cyc(FET, 1'b1, 6'd0, c, 1'b0, 1'b0);
      cyc(DEC, 1'b1, O_R,  c, 1'b0, 1'b0);
      cyc(EXE, 1'b1, 6'd0, c, 1'b0, 1'b0);
      cyc(RWB, 1'b1, 6'd0, c, 1'b0, 1'b0);
      c++;
      cyc(FET, 1'b1, 6'd0, c, 1'b0, 1'b0);
      cyc(DEC, 1'b1, O_BEQ, c, 1'b0, 1'b0);
      cyc(BRA, 1'b1, 6'd0, c, 1'b0, 1'b0);
      c++;
      cyc(FET, 1'b1, 6'd0, c, 1'b0, 1'b0);
      cyc(DEC, 1'b1, O_JAL, c, 1'b0, 1'b0);
      cyc(JLS, 1'b1, 6'd0, c, 1'b0, 1'b0);
      c++;
      cyc(FET, 1'b1, 6'd0, c, 1'b0, 1'b0);
      cyc(DEC, 1'b1, O_J,  c, 1'b0, 1'b0);
      cyc(JMS, 1'b1, 6'd0, c, 1'b0, 1'b0);
      c++;

      // illegal opcode: back to FETCH, one-cycle pulse, not counted
      cyc(FET, 1'b1, 6'd0, c, 1'b0, 1'b0);
      cyc(DEC, 1'b1, O_BAD, c, 1'b0, 1'b0);
      cyc(FET, 1'b1, 6'd0, c, 1'b1, 1'b0);
      cyc(DEC, 1'b1, O_BNE, c, 1'b0, 1'b0);
`ifdef MCU_BNE_EN
      cyc(BRA, 1'b1, 6'd0, c, 1'b0, 1'b0);
      c++;
      nxt_ill = 1'b0;
`else
      nxt_ill = 1'b1;
`endif

      // FETCH held by mem_ready low, well inside the limit
      cyc(FET, 1'b0, 6'd0, c, nxt_ill, 1'b0);
      cyc(FET, 1'b0, 6'd0, c, 1'b0, 1'b0);
      cyc(FET, 1'b1, 6'd0, c, 1'b0, 1'b0);
      cyc(DEC, 1'b1, O_J,  c, 1'b0, 1'b0);
      cyc(JMS, 1'b1, 6'd0, c, 1'b0, 1'b0);
      c++;

      // asynchronous reset in the middle of a stalled lw read
      cyc(FET, 1'b1, 6'd0, c, 1'b0, 1'b0);
      cyc(DEC, 1'b1, O_LW, c, 1'b0, 1'b0);
      cyc(MAD, 1'b1, 6'd0, c, 1'b0, 1'b0);
      cyc(MRD, 1'b0, 6'd0, c, 1'b0, 1'b0);
      cyc(MRD, 1'b0, 6'd0, c, 1'b0, 1'b0);
      u_if.mem_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_state", 32'(u_if.state),       32'd0);
      chk("midrst_ctrl",  32'(obs_ctrl),         32'd0);
      chk("midrst_count", 32'(u_if.instr_count), 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_hold", 32'(u_if.state), 32'd0);
      rst_n = 1'b1;
      cyc(IDL, 1'b1, 6'd0, 0, 1'b0, 1'b0);
      cyc(FET, 1'b1, 6'd0, 0, 1'b0, 1'b0);
      cyc(DEC, 1'b1, O_J,  0, 1'b0, 1'b0);
      cyc(JMS, 1'b1, 6'd0, 0, 1'b0, 1'b0);
      cyc(FET, 1'b1, 6'd0, 1, 1'b0, 1'b0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      // WAIT_LIMIT=4 instance, memory never ready: four FETCH cycles then a timeout pulse, repeating
      rst_t_n = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         chk("to_state",   32'(t_if.state),       (i == 0) ? 32'd0 : 32'd1);
         chk("to_pulse",   32'(t_if.mem_timeout), (i == 5 || i == 9) ? 32'd1 : 32'd0);
         chk("to_pcwrite", 32'({t_if.PCWrite, t_if.IRWrite}), 32'd0);
         chk("to_count",   32'(t_if.instr_count), 32'd0);
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
